// File: rtl/mpy_pkg.sv
// Shared definitions for the time-shared signed multiplier controller.
//   W      : operand width (two's complement)
//   CNT_W  : iteration counter width, clog2(W)
//   PW     : product width, 2*W
//   REQ0/1 : requester index constants
//   state_e: sequencer states (idle, calculating, result held)
package mpy_pkg;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned PW    = 2 * W;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/mpy_seq_arb_if.sv
// Request/response bundle between the two requesters, the consumer and the
// multiplier sequencer.
//   reqN_valid/ready/a/b : operand pair handshake from requester N
//   rsp_valid/ready      : result handshake towards the consumer
//   rsp_id               : requester that owns the result
//   rsp_product          : signed 2W-bit product
// master = requester/consumer side, slave = sequencer side.
interface mpy_seq_arb_if #(
  parameter int unsigned W = mpy_pkg::W
);

  logic           req0_valid;
  logic           req0_ready;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;
  logic           req1_valid;
  logic           req1_ready;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [2*W-1:0] rsp_product;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_product
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_product
  );

endinterface

// File: rtl/mpy_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   i_valid0/1   : requester valids
//   i_last_grant : index of the previously accepted requester
//   i_enable     : grants are only issued while enabled
//   o_gnt0/1     : one-hot grant (only to a valid requester)
//   o_gnt_id     : index of the preferred requester (meaningful with a grant)
module mpy_rr_arb2
  import mpy_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  input  logic i_enable,
  output logic o_gnt0,
  output logic o_gnt1,
  output logic o_gnt_id
);

  logic w_pick1;

  // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
  assign w_pick1  = i_valid1 & (~i_valid0 | (i_last_grant == REQ0));
  assign o_gnt1   = i_enable & w_pick1;
  assign o_gnt0   = i_enable & i_valid0 & ~w_pick1;
  assign o_gnt_id = w_pick1;

endmodule

// File: rtl/mpy_seq_arb.sv
// Two-requester, time-shared signed WxW multiplier sequencer.
// Round-robin accepts one operand pair, then accumulates one partial product
// per cycle (shift-add, with a subtract for the negatively weighted MSB of b)
// and returns the product tagged with the owning requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response bundle (slave side)
//   busy       : high whenever the sequencer is not idle
module mpy_seq_arb #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mpy_seq_arb_if.slave  bus,
  output logic          busy
);

  import mpy_pkg::*;

  localparam int unsigned ProdW = 2 * W;

  state_e             r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_id;
  logic               r_last_grant;
  logic               r_rsp_valid;
  logic               r_busy;
  logic [ProdW-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_gnt_id;
  logic               w_accept;
  logic               w_last_step;
  logic [ProdW-1:0]   w_pp;
  logic [ProdW-1:0]   w_acc_next;

  mpy_rr_arb2 u_arb (
    .i_valid0     (bus.req0_valid),
    .i_valid1     (bus.req1_valid),
    .i_last_grant (r_last_grant),
    .i_enable     (r_state == StIdle),
    .o_gnt0       (w_gnt0),
    .o_gnt1       (w_gnt1),
    .o_gnt_id     (w_gnt_id)
  );

  assign w_accept       = w_gnt0 | w_gnt1;
  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  assign w_last_step = (r_cnt == CNT_W'(W - 1));
  assign w_pp        = {{W{r_a[W-1]}}, r_a} << r_cnt;

  // Two's complement: bit W-1 of the multiplier carries weight -2^(W-1).
  always_comb begin
    w_acc_next = r_acc;
    if (r_b[r_cnt]) begin
      w_acc_next = w_last_step ? (r_acc - w_pp) : (r_acc + w_pp);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_last_grant <= REQ1;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_acc        <= '0;
      r_cnt        <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_a          <= w_gnt_id ? bus.req1_a : bus.req0_a;
            r_b          <= w_gnt_id ? bus.req1_b : bus.req0_b;
            r_id         <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_state      <= StCalc;
          end
        end
        StCalc: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last_step) begin
            r_rsp_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          // Product and id are held in r_acc/r_id until the consumer takes them.
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_id;
  assign bus.rsp_product = r_acc;
  assign busy            = r_busy;

endmodule
